// File: rtl/tone_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tone_generator_if                                            |
// | Description : Valid/ready sample stream from an oscillator to its consumer.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface tone_generator_if #(
    parameter int OUT_W = 12
);
    logic             sample_valid;
    logic             sample_ready;
    logic [OUT_W-1:0] sample;

    modport master (
        output sample_valid,
        output sample,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/tone_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tone_generator                                               |
// | Description : Phase-accumulator oscillator emitting one scaled sample per  |
// |               sample period over a one-entry valid/ready output slot.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tone_generator #(
    parameter int CLK_HZ    = 40_000,
    parameter int SAMPLE_HZ = 8_000,
    parameter int PHASE_W   = 16,
    parameter int OUT_W     = 12
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               ena,
    input  wire logic [1:0]         wave_sel,
    input  wire logic [PHASE_W-1:0] tune_word,
    input  wire logic [3:0]         volume,
    tone_generator_if.master        smp,
    output logic                    overrun
);

    localparam int                 c_TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int                 c_CNT_W    = (c_TICK_DIV > 2) ? $clog2(c_TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(c_TICK_DIV - 1);
    localparam int                 c_PROD_W   = OUT_W + 4;

    generate
        if (c_TICK_DIV < 2) begin : g_check_tick_div
            $error("tone_generator: CLK_HZ/SAMPLE_HZ must be at least 2");
        end
        if (OUT_W > PHASE_W - 1) begin : g_check_out_w
            $error("tone_generator: OUT_W must not exceed PHASE_W-1");
        end
    endgenerate

    logic [c_CNT_W-1:0]  r_count;
    logic [PHASE_W-1:0]  r_phase;
    logic [OUT_W-1:0]    r_sample;
    logic                r_valid;
    logic                r_overrun;

    logic                w_tick;
    logic [PHASE_W-1:0]  w_nphase;
    logic [OUT_W-1:0]    w_tri;
    logic [OUT_W-1:0]    w_raw;
    logic [4:0]          w_gain;
    logic [c_PROD_W-1:0] w_product;
    logic [OUT_W-1:0]    w_scaled;

    assign w_tick   = ena && (r_count == c_LAST);
    assign w_nphase = r_phase + tune_word;
    assign w_tri    = w_nphase[PHASE_W-2 -: OUT_W];

    always_comb begin
        w_raw = '0;
        case (wave_sel)
            2'd0:    w_raw = {OUT_W{w_nphase[PHASE_W-1]}};
            2'd1:    w_raw = w_nphase[PHASE_W-1 -: OUT_W];
            2'd2:    w_raw = w_nphase[PHASE_W-1] ? ~w_tri : w_tri;
            default: w_raw = '0;
        endcase
    end

    // Gain of (volume+1)/16: volume=15 multiplies by 16 and the shift undoes it exactly.
    assign w_gain    = {1'b0, volume} + 5'd1;
    assign w_product = {4'b0000, w_raw} * {{(OUT_W-1){1'b0}}, w_gain};
    assign w_scaled  = OUT_W'(w_product >> 4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count   <= '0;
            r_phase   <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!ena || r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CNT_W'(1);
            end

            // Phase advances even when the sample is dropped so pitch is preserved.
            if (w_tick) begin
                r_phase <= w_nphase;
            end

            if (w_tick && (!r_valid || smp.sample_ready)) begin
                r_sample <= w_scaled;
                r_valid  <= 1'b1;
            end else if (r_valid && smp.sample_ready) begin
                r_valid  <= 1'b0;
            end

            if (w_tick && r_valid && !smp.sample_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign smp.sample_valid = r_valid;
    assign smp.sample       = r_sample;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tone_generator                                            |
// | Description : Self-checking bench for tone_generator (vector table plus    |
// |               hand-written backpressure, enable and reset sequences).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tone_generator;

    localparam int c_NVEC = 26;

    typedef struct {
        logic [1:0]  wave;
        logic [15:0] tune;
        logic [3:0]  vol;
        logic [11:0] exp_sample;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [1:0]  wave_sel;
    logic [15:0] tune_word;
    logic [3:0]  volume;
    logic        overrun;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    vec_t        vecs[c_NVEC];

    tone_generator_if #(.OUT_W(12)) smp_if ();

    tone_generator #(
        .CLK_HZ    (40_000),
        .SAMPLE_HZ (8_000),
        .PHASE_W   (16),
        .OUT_W     (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .wave_sel  (wave_sel),
        .tune_word (tune_word),
        .volume    (volume),
        .smp       (smp_if),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic drive_cfg(input logic [1:0] w, input logic [15:0] t, input logic [3:0] v,
                             input logic [11:0] e);
        wave_sel  = w;
        tune_word = t;
        volume    = v;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the next presented sample, then pop the scoreboard and compare.
    task automatic expect_sample(input string name, input int exp_gap);
        int          n;
        bit          seen;
        logic [11:0] e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (smp_if.sample_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no sample_valid within %0d cycles", name, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_gap > 0) check({name, "_gap"}, 32'(n), 32'(exp_gap));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_sb: got 0x%0h, expected queue empty", name, smp_if.sample);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(smp_if.sample), 32'(e));
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{2'd1, 16'h1000, 4'd15, 12'((k + 1) * 256)};
        end
        vecs[16] = '{2'd2, 16'h1000, 4'd15, 12'h200};
        vecs[17] = '{2'd2, 16'h8000, 4'd15, 12'hDFF};
        vecs[18] = '{2'd0, 16'h7000, 4'd15, 12'h000};
        vecs[19] = '{2'd0, 16'h8000, 4'd15, 12'hFFF};
        vecs[20] = '{2'd1, 16'h0000, 4'd7,  12'h400};
        vecs[21] = '{2'd1, 16'h0000, 4'd0,  12'h080};
        vecs[22] = '{2'd2, 16'h4000, 4'd15, 12'h7FF};
        vecs[23] = '{2'd3, 16'h1234, 4'd15, 12'h000};
        vecs[24] = '{2'd1, 16'h0000, 4'd15, 12'hD23};
        vecs[25] = '{2'd0, 16'h0000, 4'd3,  12'h3FF};

        rst                 = 1'b0;
        ena                 = 1'b0;
        wave_sel            = 2'd0;
        tune_word           = 16'h0000;
        volume              = 4'd15;
        smp_if.sample_ready = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_valid",   32'(smp_if.sample_valid), 32'd0);
            check("rst_sample",  32'(smp_if.sample),       32'd0);
            check("rst_overrun", 32'(overrun),             32'd0);
        end

        rst                 = 1'b1;
        ena                 = 1'b1;
        smp_if.sample_ready = 1'b1;
        for (int i = 0; i < c_NVEC; i++) begin
            drive_cfg(vecs[i].wave, vecs[i].tune, vecs[i].vol, vecs[i].exp_sample);
            expect_sample($sformatf("vec%0d", i), 5);
        end

        // Backpressure: phase is 0xD234; hold ready low across two ticks.
        drive_cfg(2'd1, 16'h1000, 4'd15, 12'hE23);
        @(negedge clk);
        smp_if.sample_ready = 1'b0;
        expect_sample("bp_first", 0);
        check("bp_no_overrun_yet", 32'(overrun), 32'd0);
        repeat (4) @(negedge clk);
        check("bp_pre_tick2_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check("bp_overrun",    32'(overrun),             32'd1);
        check("bp_held",       32'(smp_if.sample),       32'hE23);
        check("bp_held_valid", 32'(smp_if.sample_valid), 32'd1);
        smp_if.sample_ready = 1'b1;
        @(negedge clk);
        check("bp_consumed", 32'(smp_if.sample_valid), 32'd0);
        exp_q.push_back(12'h023);
        expect_sample("bp_three_incr", 0);

        // Drop ena mid-period with the sample left pending.
        smp_if.sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        ena = 1'b0;
        repeat (12) @(negedge clk);
        check("ena_off_valid",  32'(smp_if.sample_valid), 32'd1);
        check("ena_off_sample", 32'(smp_if.sample),       32'h023);
        check("ena_off_overrun_sticky", 32'(overrun),     32'd1);
        ena                 = 1'b1;
        smp_if.sample_ready = 1'b1;
        drive_cfg(2'd1, 16'h1000, 4'd15, 12'h123);
        expect_sample("ena_resume", 5);

        // Reset while a sample is pending.
        smp_if.sample_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid",   32'(smp_if.sample_valid), 32'd0);
        check("midrst_overrun", 32'(overrun),             32'd0);
        check("midrst_sample",  32'(smp_if.sample),       32'd0);
        rst                 = 1'b1;
        smp_if.sample_ready = 1'b1;
        drive_cfg(2'd1, 16'h1000, 4'd15, 12'h100);
        expect_sample("midrst_phase0", 5);
        check("midrst_overrun_after", 32'(overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
